// File: rtl/rs232_pkg.sv
// Shared definitions for the rs232port bus master: register offsets, status
// bit positions and the master FSM state encoding.
package rs232_pkg;

  localparam logic [7:0] OFF_TXDATA = 8'd0;
  localparam logic [7:0] OFF_TXSTAT = 8'd1;
  localparam logic [7:0] OFF_RXDATA = 8'd2;
  localparam logic [7:0] OFF_RXSTAT = 8'd3;

  localparam int TXSTAT_FULL_BIT  = 0;
  localparam int RXSTAT_AVAIL_BIT = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TXS_REQ,
    ST_TXS_WAIT,
    ST_TX_WR,
    ST_RXS_REQ,
    ST_RXS_WAIT,
    ST_RXD_REQ,
    ST_RXD_WAIT,
    ST_GAP
  } state_e;

  // Bus addresses wrap modulo 256.
  function automatic logic [7:0] reg_addr(input logic [7:0] base, input logic [7:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/rs232_bus_master_if.sv
// Register bus between the master and one rs232port: a write port (outbus)
// and a read port (inbus) whose data returns the cycle after the strobe.
interface rs232_bus_master_if;
  logic [7:0] outbus_addr;
  logic [7:0] outbus_data;
  logic       outbus_we;
  logic [7:0] inbus_addr;
  logic       inbus_re;
  logic [7:0] inbus_data;

  modport master (
    output outbus_addr, outbus_data, outbus_we, inbus_addr, inbus_re,
    input  inbus_data
  );

  modport slave (
    input  outbus_addr, outbus_data, outbus_we, inbus_addr, inbus_re,
    output inbus_data
  );
endinterface

// File: rtl/rs232_bus_rd_seq.sv
// Two-cycle read sequencer: strobe + address in the request cycle, data
// taken in the following cycle; the address holds until the next read.
module rs232_bus_rd_seq
  import rs232_pkg::*;
#(
  parameter logic [7:0] DEVADDR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] off_i,
  input  logic [7:0] rdata_i,
  output logic       re_o,
  output logic [7:0] addr_o,
  output logic [7:0] data_o
);

  logic [7:0] addr_q, addr_d;

  assign addr_d = reg_addr(DEVADDR, off_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          addr_q <= '0;
    else if (start_i) addr_q <= addr_d;
  end

  // Strobe is combinational from the caller's state so reset drops it at once.
  assign re_o   = start_i;
  assign addr_o = start_i ? addr_d : addr_q;
  assign data_o = rdata_i;

endmodule

// File: rtl/rs232_bus_master.sv
// Polling bus master for rs232port: turns a tx byte stream and an rx byte
// stream into status/data register accesses. Optional echo: RS232_BUS_MASTER_ECHO_EN.
module rs232_bus_master
  import rs232_pkg::*;
#(
  parameter logic [7:0] DEVADDR  = 8'h00,
  parameter int         POLL_GAP = 4
) (
  input  logic                      cpu_clk,
  input  logic                      reset,
  rs232_bus_master_if.master        bus,
  input  logic [7:0]                tx_byte,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [7:0]                rx_byte,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      busy
);

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  state_e     st_q, st_d;
  logic       rd_start;
  logic [7:0] rd_off;
  logic [7:0] rd_data;
  logic       wr_we;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [GW-1:0] gap_q, gap_d;
  logic       echo_pend;
  logic [7:0] echo_byte;
  logic       rx_blk;
  state_e     end_round, rx_chk;

  rs232_bus_rd_seq #(.DEVADDR(DEVADDR)) u_rd_seq (
    .clk     (cpu_clk),
    .rst     (reset),
    .start_i (rd_start),
    .off_i   (rd_off),
    .rdata_i (bus.inbus_data),
    .re_o    (bus.inbus_re),
    .addr_o  (bus.inbus_addr),
    .data_o  (rd_data)
  );

  // A pending echo also blocks the rx poll so a second byte cannot overwrite it;
  // it is released in the same TX_WR cycle that drains it.
  assign rx_blk    = rx_valid_q | (echo_pend & (st_q != ST_TX_WR));
  assign end_round = (POLL_GAP == 0) ? ST_IDLE : ST_GAP;
  assign rx_chk    = rx_blk ? end_round : ST_RXS_REQ;

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) st_q <= ST_IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: begin
        if (echo_pend || tx_valid) st_d = ST_TXS_REQ;
        else if (!rx_valid_q)      st_d = ST_RXS_REQ;
      end
      ST_TXS_REQ:  st_d = ST_TXS_WAIT;
      ST_TXS_WAIT: st_d = rd_data[TXSTAT_FULL_BIT] ? rx_chk : ST_TX_WR;
      ST_TX_WR:    st_d = rx_chk;
      ST_RXS_REQ:  st_d = ST_RXS_WAIT;
      ST_RXS_WAIT: st_d = rd_data[RXSTAT_AVAIL_BIT] ? ST_RXD_REQ : end_round;
      ST_RXD_REQ:  st_d = ST_RXD_WAIT;
      ST_RXD_WAIT: st_d = end_round;
      ST_GAP:      st_d = (gap_q == GAP_LAST) ? ST_IDLE : ST_GAP;
      default:     st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_start = 1'b0;
    rd_off   = OFF_RXSTAT;
    wr_we    = 1'b0;
    tx_ready = 1'b0;
    busy     = 1'b1;
    case (st_q)
      ST_TXS_REQ: begin rd_start = 1'b1; rd_off = OFF_TXSTAT; end
      ST_RXS_REQ: begin rd_start = 1'b1; rd_off = OFF_RXSTAT; end
      ST_RXD_REQ: begin rd_start = 1'b1; rd_off = OFF_RXDATA; end
      ST_TX_WR:   begin wr_we = 1'b1; tx_ready = ~echo_pend; end
      ST_IDLE, ST_GAP: busy = 1'b0;
      default: ;
    endcase
  end

  assign bus.outbus_we   = wr_we;
  assign bus.outbus_addr = wr_we ? reg_addr(DEVADDR, OFF_TXDATA) : 8'h00;
  assign bus.outbus_data = wr_we ? (echo_pend ? echo_byte : tx_byte) : 8'h00;

  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_byte_d  = rx_byte_q;
    if (st_q == ST_RXD_WAIT) begin
      rx_valid_d = 1'b1;
      rx_byte_d  = rd_data;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_byte  = rx_byte_q;

  assign gap_d = (st_q == ST_GAP) ? gap_q + 1'b1 : '0;

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) gap_q <= '0;
    else       gap_q <= gap_d;
  end

`ifdef RS232_BUS_MASTER_ECHO_EN
  logic       echo_pend_q, echo_pend_d;
  logic [7:0] echo_byte_q, echo_byte_d;

  always_comb begin
    echo_pend_d = echo_pend_q;
    echo_byte_d = echo_byte_q;
    if (st_q == ST_RXD_WAIT) begin
      echo_pend_d = 1'b1;
      echo_byte_d = rd_data;
    end else if (st_q == ST_TX_WR) begin
      echo_pend_d = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      echo_pend_q <= 1'b0;
      echo_byte_q <= '0;
    end else begin
      echo_pend_q <= echo_pend_d;
      echo_byte_q <= echo_byte_d;
    end
  end

  assign echo_pend = echo_pend_q;
  assign echo_byte = echo_byte_q;
`else
  assign echo_pend = 1'b0;
  assign echo_byte = 8'h00;
`endif

endmodule

// File: tb/tb_rs232_bus_master.sv
// Directed bench for rs232_bus_master with a small rs232port register model.
module tb_rs232_bus_master;

  localparam logic [7:0] DEVADDR  = 8'hFE;
  localparam int         POLL_GAP = 4;
  localparam logic [7:0] A_TXD = 8'hFE;
  localparam logic [7:0] A_TXS = 8'hFF;
  localparam logic [7:0] A_RXD = 8'h00;
  localparam logic [7:0] A_RXS = 8'h01;

  logic       cpu_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       busy;

  always #5 cpu_clk = ~cpu_clk;

  rs232_bus_master_if bus();

  rs232_bus_master #(.DEVADDR(DEVADDR), .POLL_GAP(POLL_GAP)) dut (
    .cpu_clk  (cpu_clk),
    .reset    (reset),
    .bus      (bus),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;

  // rs232port model + bus monitor
  int cyc = 0, n_rd_txs = 0, n_rd_rxs = 0, n_rd_rxd = 0, n_rd_other = 0;
  int n_wr = 0, n_txrdy = 0, n_both = 0, rxs_last = 0, rxs_prev = 0;
  int tx_full_until = 0;
  int rx_wr = 0, rx_rd = 0;
  logic [7:0] rx_src [0:15];

  always @(posedge cpu_clk) begin
    cyc <= cyc + 1;
    if (bus.outbus_we) n_wr <= n_wr + 1;
    if (tx_ready) n_txrdy <= n_txrdy + 1;
    if (bus.outbus_we && bus.inbus_re) n_both <= n_both + 1;
    if (bus.inbus_re) begin
      case (bus.inbus_addr)
        A_TXS: begin
          bus.inbus_data <= {7'd0, n_rd_txs < tx_full_until};
          n_rd_txs <= n_rd_txs + 1;
        end
        A_RXS: begin
          bus.inbus_data <= {7'd0, rx_rd != rx_wr};
          n_rd_rxs <= n_rd_rxs + 1;
          rxs_prev <= rxs_last;
          rxs_last <= cyc;
        end
        A_RXD: begin
          bus.inbus_data <= rx_src[rx_rd[3:0]];
          rx_rd <= rx_rd + 1;
          n_rd_rxd <= n_rd_rxd + 1;
        end
        default: begin
          bus.inbus_data <= 8'hEE;
          n_rd_other <= n_rd_other + 1;
        end
      endcase
    end
  end

  // tx_byte must not change while tx_valid is held and not yet accepted
  logic       rdy_neg = 1'b0;
  logic       pv = 1'b0;
  logic [7:0] pb = 8'h00;
  int         asrt_bad = 0;

  always @(negedge cpu_clk) rdy_neg <= tx_ready;

  always @(posedge cpu_clk) begin
    if (pv) begin
      assert (tx_byte === pb)
      else begin
        $display("FAIL tx_byte_stable got=%0h want=%0h", tx_byte, pb);
        asrt_bad <= asrt_bad + 1;
      end
    end
    pv <= tx_valid && !rdy_neg && !reset;
    pb <= tx_byte;
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge cpu_clk);
    total++;
    if ({bus.outbus_we, bus.inbus_re, tx_ready, rx_valid, busy} !== 5'b0) begin
      $display("FAIL reset_strobes got=%b want=00000",
               {bus.outbus_we, bus.inbus_re, tx_ready, rx_valid, busy}); bad++;
    end
    total++;
    if ({bus.outbus_addr, bus.outbus_data, bus.inbus_addr, rx_byte} !== 32'h0) begin
      $display("FAIL reset_data got=%h want=0",
               {bus.outbus_addr, bus.outbus_data, bus.inbus_addr, rx_byte}); bad++;
    end
    reset = 1'b0;
    @(negedge cpu_clk);
    total++;
    if (bus.inbus_re !== 1'b1 || bus.inbus_addr !== A_RXS) begin
      $display("FAIL first_poll got re=%b addr=%h want re=1 addr=%h",
               bus.inbus_re, bus.inbus_addr, A_RXS); bad++;
    end
    @(negedge cpu_clk);
    total++;
    if (bus.inbus_re !== 1'b0 || bus.inbus_addr !== A_RXS || busy !== 1'b1) begin
      $display("FAIL poll_wait got re=%b addr=%h busy=%b want 0/%h/1",
               bus.inbus_re, bus.inbus_addr, busy, A_RXS); bad++;
    end
    @(negedge cpu_clk);
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL gap_not_busy got=%b want=0", busy); bad++;
    end
  endtask

  task automatic test_poll();
    int rxs0, wr0;
    rxs0 = n_rd_rxs;
    wr0  = n_wr;
    repeat (30) @(negedge cpu_clk);
    total++;
    if (n_rd_rxs - rxs0 < 4 || n_rd_rxs - rxs0 > 5) begin
      $display("FAIL poll_count got=%0d want=4..5", n_rd_rxs - rxs0); bad++;
    end
    total++;
    if (rxs_last - rxs_prev != 3 + POLL_GAP) begin
      $display("FAIL poll_period got=%0d want=%0d", rxs_last - rxs_prev, 3 + POLL_GAP); bad++;
    end
    total++;
    if (n_wr != wr0 || n_rd_txs != 0 || rx_valid !== 1'b0) begin
      $display("FAIL poll_quiet got wr=%0d txs=%0d rxv=%b want 0/0/0",
               n_wr - wr0, n_rd_txs, rx_valid); bad++;
    end
  endtask

  task automatic test_tx();
    int txs0;
    txs0 = n_rd_txs;
    tx_byte  = 8'h53;
    tx_valid = 1'b1;
    for (int i = 0; i < 40 && tx_ready !== 1'b1; i++) @(negedge cpu_clk);
    total++;
    if (tx_ready !== 1'b1) begin
      $display("FAIL tx_accept_timeout got=%b want=1", tx_ready); bad++;
    end
    total++;
    if (bus.outbus_we !== 1'b1 || bus.outbus_addr !== A_TXD ||
        bus.outbus_data !== 8'h53 || bus.inbus_re !== 1'b0) begin
      $display("FAIL tx_write got we=%b a=%h d=%h re=%b want 1/%h/53/0",
               bus.outbus_we, bus.outbus_addr, bus.outbus_data, bus.inbus_re, A_TXD); bad++;
    end
    total++;
    if (n_rd_txs != txs0 + 1) begin
      $display("FAIL tx_status_reads got=%0d want=1", n_rd_txs - txs0); bad++;
    end
    @(negedge cpu_clk);
    total++;
    if (tx_ready !== 1'b0 || bus.outbus_we !== 1'b0) begin
      $display("FAIL tx_one_cycle got rdy=%b we=%b want 0/0", tx_ready, bus.outbus_we); bad++;
    end
    tx_byte = 8'h0d;
    txs0 = n_rd_txs;
    for (int i = 0; i < 40 && tx_ready !== 1'b1; i++) @(negedge cpu_clk);
    total++;
    if (tx_ready !== 1'b1 || bus.outbus_data !== 8'h0d || n_rd_txs != txs0 + 1) begin
      $display("FAIL tx_second got rdy=%b d=%h txs=%0d want 1/0d/1",
               tx_ready, bus.outbus_data, n_rd_txs - txs0); bad++;
    end
    @(negedge cpu_clk);
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
  endtask

  task automatic test_tx_full();
    int txs0, rdy0, wr0;
    txs0 = n_rd_txs;
    rdy0 = n_txrdy;
    wr0  = n_wr;
    tx_full_until = txs0 + 3;
    tx_byte  = 8'h77;
    tx_valid = 1'b1;
    for (int i = 0; i < 100 && tx_ready !== 1'b1; i++) @(negedge cpu_clk);
    total++;
    if (tx_ready !== 1'b1 || bus.outbus_data !== 8'h77) begin
      $display("FAIL full_accept got rdy=%b d=%h want 1/77", tx_ready, bus.outbus_data); bad++;
    end
    total++;
    if (n_rd_txs - txs0 != 4 || n_wr != wr0) begin
      $display("FAIL full_rounds got polls=%0d writes=%0d want 4/0", n_rd_txs - txs0, n_wr - wr0); bad++;
    end
    @(negedge cpu_clk);
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    repeat (20) @(negedge cpu_clk);
    total++;
    if (n_txrdy - rdy0 != 1 || n_wr - wr0 != 1) begin
      $display("FAIL full_single got rdy=%0d wr=%0d want 1/1", n_txrdy - rdy0, n_wr - wr0); bad++;
    end
  endtask

  task automatic test_rx_backpressure();
    int rxs0, rxd0;
    rx_src[rx_wr[3:0]] = 8'h41; rx_wr = rx_wr + 1;
    rx_src[rx_wr[3:0]] = 8'h42; rx_wr = rx_wr + 1;
    for (int i = 0; i < 40 && rx_valid !== 1'b1; i++) @(negedge cpu_clk);
    total++;
    if (rx_valid !== 1'b1 || rx_byte !== 8'h41) begin
      $display("FAIL rx_first got v=%b b=%h want 1/41", rx_valid, rx_byte); bad++;
    end
    rxs0 = n_rd_rxs;
    rxd0 = n_rd_rxd;
    repeat (20) @(negedge cpu_clk);
    total++;
    if (rx_valid !== 1'b1 || rx_byte !== 8'h41 || busy !== 1'b0) begin
      $display("FAIL rx_hold got v=%b b=%h busy=%b want 1/41/0", rx_valid, rx_byte, busy); bad++;
    end
    total++;
    if (n_rd_rxs != rxs0 || n_rd_rxd != rxd0 || rx_rd != rx_wr - 1) begin
      $display("FAIL rx_no_poll got rxs=%0d rxd=%0d left=%0d want 0/0/1",
               n_rd_rxs - rxs0, n_rd_rxd - rxd0, rx_wr - rx_rd); bad++;
    end
    rx_ready = 1'b1;
    @(negedge cpu_clk);
    rx_ready = 1'b0;
    total++;
    if (rx_valid !== 1'b0) begin
      $display("FAIL rx_clear got=%b want=0", rx_valid); bad++;
    end
    for (int i = 0; i < 40 && rx_valid !== 1'b1; i++) @(negedge cpu_clk);
    total++;
    if (rx_valid !== 1'b1 || rx_byte !== 8'h42 || rx_rd != rx_wr) begin
      $display("FAIL rx_second got v=%b b=%h left=%0d want 1/42/0", rx_valid, rx_byte, rx_wr - rx_rd); bad++;
    end
    rx_ready = 1'b1;
    @(negedge cpu_clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    rx_src[rx_wr[3:0]] = 8'h55; rx_wr = rx_wr + 1;
    for (int i = 0; i < 40 && !(bus.inbus_re === 1'b1 && bus.inbus_addr === A_RXD); i++)
      @(negedge cpu_clk);
    total++;
    if (bus.inbus_re !== 1'b1 || bus.inbus_addr !== A_RXD) begin
      $display("FAIL rxd_req_timeout got re=%b a=%h want 1/%h", bus.inbus_re, bus.inbus_addr, A_RXD); bad++;
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.inbus_re !== 1'b0 || rx_valid !== 1'b0 || busy !== 1'b0 || bus.inbus_addr !== 8'h00) begin
      $display("FAIL async_reset got re=%b rxv=%b busy=%b a=%h want 0/0/0/00",
               bus.inbus_re, rx_valid, busy, bus.inbus_addr); bad++;
    end
    @(negedge cpu_clk);
    reset = 1'b0;
    total++;
    if (rx_rd != rx_wr - 1) begin
      $display("FAIL reset_no_pop got left=%0d want=1", rx_wr - rx_rd); bad++;
    end
    @(negedge cpu_clk);
    total++;
    if (bus.inbus_re !== 1'b1 || bus.inbus_addr !== A_RXS) begin
      $display("FAIL restart_poll got re=%b a=%h want 1/%h", bus.inbus_re, bus.inbus_addr, A_RXS); bad++;
    end
    for (int i = 0; i < 40 && rx_valid !== 1'b1; i++) @(negedge cpu_clk);
    total++;
    if (rx_valid !== 1'b1 || rx_byte !== 8'h55) begin
      $display("FAIL restart_rx got v=%b b=%h want 1/55", rx_valid, rx_byte); bad++;
    end
    rx_ready = 1'b1;
    @(negedge cpu_clk);
    rx_ready = 1'b0;
    repeat (12) @(negedge cpu_clk);
  endtask

`ifdef RS232_BUS_MASTER_ECHO_EN
  task automatic test_echo();
    int rdy0;
    rdy0 = n_txrdy;
    tx_full_until = n_rd_txs + 1000;
    tx_byte  = 8'h53;
    tx_valid = 1'b1;
    rx_src[rx_wr[3:0]] = 8'h61; rx_wr = rx_wr + 1;
    for (int i = 0; i < 60 && rx_valid !== 1'b1; i++) @(negedge cpu_clk);
    total++;
    if (rx_valid !== 1'b1 || rx_byte !== 8'h61) begin
      $display("FAIL echo_rx got v=%b b=%h want 1/61", rx_valid, rx_byte); bad++;
    end
    tx_full_until = 0;
    for (int i = 0; i < 40 && bus.outbus_we !== 1'b1; i++) @(negedge cpu_clk);
    total++;
    if (bus.outbus_we !== 1'b1 || bus.outbus_data !== 8'h61 || tx_ready !== 1'b0 || n_txrdy != rdy0) begin
      $display("FAIL echo_write got we=%b d=%h rdy=%b pulses=%0d want 1/61/0/0",
               bus.outbus_we, bus.outbus_data, tx_ready, n_txrdy - rdy0); bad++;
    end
    @(negedge cpu_clk);
    for (int i = 0; i < 40 && tx_ready !== 1'b1; i++) @(negedge cpu_clk);
    total++;
    if (tx_ready !== 1'b1 || bus.outbus_data !== 8'h53) begin
      $display("FAIL echo_then_tx got rdy=%b d=%h want 1/53", tx_ready, bus.outbus_data); bad++;
    end
    @(negedge cpu_clk);
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    @(negedge cpu_clk);
    rx_ready = 1'b0;
  endtask
`endif

  task automatic test_protocol();
    total++;
    if (n_both != 0 || n_rd_other != 0) begin
      $display("FAIL strobe_rules got both=%0d stray=%0d want 0/0", n_both, n_rd_other); bad++;
    end
    total++;
    if (asrt_bad != 0) begin
      $display("FAIL tx_byte_protocol got=%0d want=0", asrt_bad); bad++;
    end
  endtask

  initial begin
    test_reset();
    test_poll();
    test_tx();
    test_tx_full();
    test_rx_backpressure();
    test_reset_mid();
`ifdef RS232_BUS_MASTER_ECHO_EN
    test_echo();
`endif
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs232_bus_master.md
Name: rs232_bus_master

Overview:
- CPU-side initiator for the rs232port register interface: drives outbus/inbus transactions that poll, read and write the port.
- Converts two byte streams (tx in, rx out, valid/ready) into register accesses, so stream logic needs no bus sequencing.
- Sits between user logic and one rs232port instance, clocked on the CPU clock domain.

Parameters:
- DEVADDR, 0, base address of the target rs232port; all bus addresses are DEVADDR+offset, 8-bit wrap.
- POLL_GAP, 4, idle cycles between poll rounds (0 allowed = back-to-back rounds).

Ports:
- cpu_clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- outbus_addr  out  8  write address.
- outbus_data  out  8  write data.
- outbus_we  out  1  single-cycle write strobe.
- inbus_addr  out  8  read address.
- inbus_re  out  1  single-cycle read strobe.
- inbus_data  in  8  read data, valid the cycle after inbus_re.
- tx_byte  in  8  byte to transmit.
- tx_valid  in  1  tx_byte valid; held until accepted.
- tx_ready  out  1  one-cycle accept pulse for tx_byte.
- rx_byte  out  8  received byte.
- rx_valid  out  1  rx_byte valid; held until rx_ready.
- rx_ready  in  1  consumer accepts rx_byte.
- busy  out  1  FSM not in IDLE/GAP.

Behaviour:
- Register map: +0 write = tx data; +1 read = tx status (bit0 = tx full); +2 read = rx data (read pops); +3 read = rx status (bit0 = rx available).
- Reset: all outputs 0; rx holding reg empty; FSM = IDLE; gap counter 0. Reset mid-transaction drops strobes immediately; no partial transaction resumes.
- Read op: cycle N: inbus_addr set, inbus_re=1. Cycle N+1: inbus_re=0, inbus_data sampled. inbus_addr holds until the next op.
- Write op: outbus_addr, outbus_data, outbus_we=1 for exactly one cycle.
- Only one strobe is asserted in any cycle.
- FSM states: IDLE, TXS_REQ, TXS_WAIT, TX_WR, RXS_REQ, RXS_WAIT, RXD_REQ, RXD_WAIT, GAP.
- IDLE: if tx_valid, go to TXS_REQ. Else, if the holding reg is empty, go to RXS_REQ. Else stay.
- TXS_WAIT: if bit0=0, go to TX_WR. Else skip to the rx check.
- TX_WR: outbus_we pulse with tx_byte; tx_ready=1 in the same cycle; then go to the rx check.
- rx check: if the holding reg is empty, go to RXS_REQ. Else go to GAP.
- RXS_WAIT: if bit0=1, go to RXD_REQ. Else go to GAP.
- RXD_WAIT: load rx_byte from inbus_data, rx_valid=1, then go to GAP.
- GAP: count POLL_GAP cycles, then go to IDLE. With POLL_GAP=0, go directly to IDLE.
- Tx always precedes rx within a round, so neither direction starves.
- rx_valid clears on the cycle after rx_valid&rx_ready. The rx status register is never polled while the holding reg is full, so no byte is lost.
- tx_byte is sampled in TX_WR only. Changing it while tx_valid is held is a protocol violation (checked by an assertion in the bench).
- Max one tx byte and one rx byte per round.

Optional Feature:
- Macro: RS232_BUS_MASTER_ECHO_EN.
- Enabled: each byte loaded in RXD_WAIT also sets an echo-pending flag with a copy of the byte. At the next IDLE, a pending echo takes priority over tx_valid: it uses the same status poll and write sequence and does not pulse tx_ready. tx_ready stays 0 while echo is pending. rx_valid is still presented to the consumer.
- Disabled: no echo logic; behaviour as above.

Decomposition:
- Shared package rs232_pkg: register offsets (TXDATA=0, TXSTAT=1, RXDATA=2, RXSTAT=3), status bit indices, FSM state typedef.
- One natural sub-module, rs232_bus_rd_seq: the 2-cycle read sequencer (addr/re/sample), instanced once and reused by all read states.

Test Plan:
- Reset released, no tx, model reports +3 bit0=0: polls +3 every 2+POLL_GAP+1 cycles; outbus_we never asserts; rx_valid=0.
- tx_valid with tx_byte=0x53, +1 bit0=0: read +1, then write +0 data 0x53 with one outbus_we pulse; tx_ready pulses in the same cycle. Then 0x0d follows in the next round.
- +1 bit0=1 for 3 rounds, then 0: no write until the 4th round; tx_valid held throughout; exactly one tx_ready.
- Model has 0x41 pending: read +3 (=1), read +2 → rx_byte=0x41, rx_valid=1. With rx_ready held 0 for 20 cycles: no further +3/+2 reads; second byte 0x42 is retained by the model. Then rx_ready → 0x42 follows.
- reset asserted while inbus_re=1 in RXD_REQ: inbus_re and rx_valid go 0 asynchronously. After release, restart from IDLE and re-read +3.
- ECHO_EN build: rx 0x61 → subsequent write +0 data 0x61 before a held user tx_byte 0x53. tx_ready stays 0 until the echo completes, then 0x53 is written.
